crack_sweep: RTL and testbench

`crack_sweep` is the upstream controller for one ARC4 `crack` engine. It divides the 24-bit key space into fixed-size chunks and issues them to the engine one at a time via the engine's `en`/`rdy` handshake and `low_key`/`high_key` bounds. It stops at the first chunk that reports a valid key, or after the last chunk. It presents a single `en`/`rdy`/`key`/`key_valid` interface to the top level.

---
 rtl/crack_sweep.sv | 105 ++++++++++
 tb/tb_crack_sweep.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crack_sweep.sv
// crack_sweep: walks the 24-bit key space in fixed chunks through one crack engine.
// Stops at the first chunk reporting a key, or after the chunk ending at KEY_MAX.
module crack_sweep #(
    parameter logic [23:0] CHUNK   = 24'h010000,
    parameter logic [23:0] KEY_MAX = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic [23:0] cur_low,
    output logic        crk_en,
    input  logic        crk_rdy,
    output logic [23:0] crk_low_key,
    output logic [23:0] crk_high_key,
    input  logic [23:0] crk_key,
    input  logic        crk_key_valid
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        PULSE,
        WAIT_ACK,
        WAIT_DONE,
        DONE
    } state_t;

    state_t      state;
    logic [23:0] base;
    logic [24:0] sum;
    logic [23:0] hi;

    // 25-bit sum so a chunk running past the top of the key space cannot wrap
    assign sum = {1'b0, base} + {1'b0, CHUNK} - 25'd1;
    assign hi  = (sum > {1'b0, KEY_MAX}) ? KEY_MAX : sum[23:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            base         <= '0;
            rdy          <= 1'b1;
            key          <= '0;
            key_valid    <= 1'b0;
            cur_low      <= '0;
            crk_en       <= 1'b0;
            crk_low_key  <= '0;
            crk_high_key <= '0;
        end else begin
            crk_en <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (en) begin
                        base      <= '0;
                        key       <= '0;
                        key_valid <= 1'b0;
                        rdy       <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    crk_low_key  <= base;
                    crk_high_key <= hi;
                    cur_low      <= base;
                    if (crk_rdy) begin
                        crk_en <= 1'b1;
                        state  <= PULSE;
                    end
                end
                PULSE: begin
                    state <= WAIT_ACK;
                end
                // the engine may still show the previous result here
                WAIT_ACK: begin
                    if (!crk_rdy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (crk_rdy) begin
                        if (crk_key_valid) begin
                            key       <= crk_key;
                            key_valid <= 1'b1;
                            rdy       <= 1'b1;
                            state     <= DONE;
                        end else if (crk_high_key == KEY_MAX) begin
                            key_valid <= 1'b0;
                            rdy       <= 1'b1;
                            state     <= DONE;
                        end else begin
                            base  <= crk_high_key + 24'd1;
                            state <= ISSUE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crack_sweep.sv
// Bench for crack_sweep: two instances (4 and 3 chunks) each driving a
// behavioural crack engine with configurable match key, delay and stale-ready.
module tb_crack_sweep;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en [2];
    logic        rdy [2];
    logic [23:0] key [2];
    logic        kv [2];
    logic [23:0] cur_low [2];
    logic        c_en [2];
    logic [23:0] c_lo [2];
    logic [23:0] c_hi [2];
    logic        e_rdy [2];
    logic [23:0] e_key [2];
    logic        e_kv [2];

    crack_sweep #(.CHUNK(24'h400000), .KEY_MAX(24'hFFFFFF)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]),
        .key(key[0]), .key_valid(kv[0]), .cur_low(cur_low[0]),
        .crk_en(c_en[0]), .crk_rdy(e_rdy[0]),
        .crk_low_key(c_lo[0]), .crk_high_key(c_hi[0]),
        .crk_key(e_key[0]), .crk_key_valid(e_kv[0])
    );

    crack_sweep #(.CHUNK(24'h600000), .KEY_MAX(24'hFFFFFF)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]),
        .key(key[1]), .key_valid(kv[1]), .cur_low(cur_low[1]),
        .crk_en(c_en[1]), .crk_rdy(e_rdy[1]),
        .crk_low_key(c_lo[1]), .crk_high_key(c_hi[1]),
        .crk_key(e_key[1]), .crk_key_valid(e_kv[1])
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          dly = 4;
    int          phase [2];
    int          cnt [2];
    int          hold_until [2];
    int          stale [2];
    logic [23:0] mk [2];
    logic        men [2];
    logic [23:0] elo [2];
    logic [23:0] ehi [2];

    // behavioural engine: optional busy hold, optional stale-ready window
    always @(posedge clk or negedge rst_n) begin
        bit hit;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                e_rdy[i] <= 1'b1;
                e_kv[i]  <= 1'b0;
                e_key[i] <= '0;
                phase[i] = 0;
                cnt[i] = 0;
            end else begin
                case (phase[i])
                    0: begin
                        if (cyc < hold_until[i]) begin
                            e_rdy[i] <= 1'b0;
                        end else if (!e_rdy[i]) begin
                            e_rdy[i] <= 1'b1;
                        end else if (c_en[i]) begin
                            elo[i] = c_lo[i];
                            ehi[i] = c_hi[i];
                            if (stale[i] > 0) begin
                                phase[i] = 1;
                                cnt[i] = stale[i];
                                e_kv[i]  <= 1'b1;
                                e_key[i] <= 24'hBAD000;
                            end else begin
                                phase[i] = 2;
                                cnt[i] = dly;
                                e_rdy[i] <= 1'b0;
                            end
                        end
                    end
                    1: begin
                        cnt[i] = cnt[i] - 1;
                        if (cnt[i] == 0) begin
                            phase[i] = 2;
                            cnt[i] = dly;
                            e_rdy[i] <= 1'b0;
                            e_kv[i]  <= 1'b0;
                        end
                    end
                    2: begin
                        cnt[i] = cnt[i] - 1;
                        if (cnt[i] == 0) begin
                            hit = men[i] && (mk[i] >= elo[i]) && (mk[i] <= ehi[i]);
                            phase[i] = 0;
                            e_rdy[i] <= 1'b1;
                            e_kv[i]  <= hit;
                            e_key[i] <= hit ? mk[i] : 24'h0;
                        end
                    end
                    default: phase[i] = 0;
                endcase
            end
        end
    end

    int          pcnt [2];
    logic [23:0] plo [2][64];
    logic [23:0] phi [2][64];
    int          pgap [2][64];
    int          rise_cyc [2];
    int          done_cyc [2];
    int          dbl_cnt [2];
    logic        prev_en [2];
    logic        prev_er [2];
    logic        prev_rdy [2];

    // pulse log and edge timestamps
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (e_rdy[i] === 1'b1 && prev_er[i] !== 1'b1) rise_cyc[i] = cyc;
            if (rdy[i] === 1'b1 && prev_rdy[i] !== 1'b1) done_cyc[i] = cyc;
            if (c_en[i] === 1'b1) begin
                if (prev_en[i] === 1'b1) dbl_cnt[i] = dbl_cnt[i] + 1;
                if (pcnt[i] < 64) begin
                    plo[i][pcnt[i]] = c_lo[i];
                    phi[i][pcnt[i]] = c_hi[i];
                    pgap[i][pcnt[i]] = cyc - rise_cyc[i];
                end
                pcnt[i] = pcnt[i] + 1;
            end
            prev_en[i] = c_en[i];
            prev_er[i] = e_rdy[i];
            prev_rdy[i] = rdy[i];
        end
    end

    logic [23:0] exp_lo4 [4] = '{24'h000000, 24'h400000, 24'h800000, 24'hC00000};
    logic [23:0] exp_hi4 [4] = '{24'h3FFFFF, 24'h7FFFFF, 24'hBFFFFF, 24'hFFFFFF};

    task automatic pulse_en(input int i);
        @(negedge clk);
        en[i] = 1'b1;
        @(negedge clk);
        en[i] = 1'b0;
    endtask

    task automatic wait_rdy(input int i, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (rdy[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++;
        if ({rdy[0], kv[0], c_en[0]} !== 3'b100) begin
            fails++;
            $display("FAIL reset_flags: got rdy/kv/crk_en=%b, expected 100", {rdy[0], kv[0], c_en[0]});
        end
        tests++;
        if ({key[0], cur_low[0], c_lo[0], c_hi[0]} !== 96'h0) begin
            fails++;
            $display("FAIL reset_values: got key=%h cur_low=%h lo=%h hi=%h, expected all 0",
                     key[0], cur_low[0], c_lo[0], c_hi[0]);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({rdy[0], c_en[0], rdy[1], c_en[1]} !== 4'b1010) begin
            fails++;
            $display("FAIL reset_release: got rdy0/en0/rdy1/en1=%b, expected 1010",
                     {rdy[0], c_en[0], rdy[1], c_en[1]});
        end
    endtask

    task automatic test_full_miss;
        int p0;
        bit ok;
        men[0] = 1'b0;
        p0 = pcnt[0];
        pulse_en(0);
        tests++;
        if (rdy[0] !== 1'b0 || c_en[0] !== 1'b0) begin
            fails++;
            $display("FAIL start_rdy: got rdy=%b crk_en=%b, expected 0 0", rdy[0], c_en[0]);
        end
        @(negedge clk);
        tests++;
        if (c_en[0] !== 1'b1) begin
            fails++;
            $display("FAIL start_latency: got crk_en=%b, expected 1", c_en[0]);
        end
        wait_rdy(0, 200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL miss_timeout: got rdy=%b, expected 1 within budget", rdy[0]);
        end
        tests++;
        if (pcnt[0] - p0 !== 4) begin
            fails++;
            $display("FAIL miss_pulses: got %0d, expected 4", pcnt[0] - p0);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (plo[0][p0+k] !== exp_lo4[k] || phi[0][p0+k] !== exp_hi4[k]) begin
                fails++;
                $display("FAIL miss_bounds%0d: got %h-%h, expected %h-%h",
                         k, plo[0][p0+k], phi[0][p0+k], exp_lo4[k], exp_hi4[k]);
            end
        end
        tests++;
        if (pgap[0][p0+3] !== 2) begin
            fails++;
            $display("FAIL chunk_gap: got %0d, expected 2", pgap[0][p0+3]);
        end
        tests++;
        if (kv[0] !== 1'b0 || cur_low[0] !== 24'hC00000) begin
            fails++;
            $display("FAIL miss_result: got kv=%b cur_low=%h, expected 0 c00000", kv[0], cur_low[0]);
        end
    endtask

    task automatic test_hit;
        int p0;
        bit ok;
        men[0] = 1'b1;
        mk[0] = 24'h8A1234;
        p0 = pcnt[0];
        pulse_en(0);
        wait_rdy(0, 200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL hit_timeout: got rdy=%b, expected 1 within budget", rdy[0]);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (pcnt[0] - p0 !== 3) begin
            fails++;
            $display("FAIL hit_pulses: got %0d, expected 3", pcnt[0] - p0);
        end
        tests++;
        if (key[0] !== 24'h8A1234 || kv[0] !== 1'b1) begin
            fails++;
            $display("FAIL hit_key: got key=%h kv=%b, expected 8a1234 1", key[0], kv[0]);
        end
        tests++;
        if (done_cyc[0] - rise_cyc[0] !== 1) begin
            fails++;
            $display("FAIL hit_latency: got %0d, expected 1", done_cyc[0] - rise_cyc[0]);
        end
    endtask

    task automatic test_partial;
        int p0;
        bit ok;
        men[1] = 1'b0;
        p0 = pcnt[1];
        pulse_en(1);
        wait_rdy(1, 200, ok);
        tests++;
        if (!ok || pcnt[1] - p0 !== 3) begin
            fails++;
            $display("FAIL partial_pulses: got %0d (ok=%b), expected 3", pcnt[1] - p0, ok);
        end
        tests++;
        if (phi[1][p0] !== 24'h5FFFFF || plo[1][p0+1] !== 24'h600000 || phi[1][p0+1] !== 24'hBFFFFF) begin
            fails++;
            $display("FAIL partial_mid: got hi0=%h lo1=%h hi1=%h, expected 5fffff 600000 bfffff",
                     phi[1][p0], plo[1][p0+1], phi[1][p0+1]);
        end
        tests++;
        if (plo[1][p0+2] !== 24'hC00000 || phi[1][p0+2] !== 24'hFFFFFF) begin
            fails++;
            $display("FAIL partial_last: got %h-%h, expected c00000-ffffff", plo[1][p0+2], phi[1][p0+2]);
        end
        tests++;
        if (kv[1] !== 1'b0) begin
            fails++;
            $display("FAIL partial_kv: got %b, expected 0", kv[1]);
        end
    endtask

    task automatic test_handshake;
        int p0;
        bit ok;
        men[0] = 1'b1;
        mk[0] = 24'h123456;
        stale[0] = 3;
        p0 = pcnt[0];
        hold_until[0] = cyc + 5;
        pulse_en(0);
        repeat (2) @(negedge clk);
        tests++;
        if (pcnt[0] - p0 !== 0 || rdy[0] !== 1'b0) begin
            fails++;
            $display("FAIL busy_no_pulse: got pulses=%0d rdy=%b, expected 0 0", pcnt[0] - p0, rdy[0]);
        end
        wait_rdy(0, 200, ok);
        tests++;
        if (!ok || pcnt[0] - p0 !== 1 || plo[0][p0] !== 24'h0) begin
            fails++;
            $display("FAIL busy_pulse: got pulses=%0d lo=%h ok=%b, expected 1 000000", pcnt[0] - p0, plo[0][p0], ok);
        end
        tests++;
        if (key[0] !== 24'h123456 || kv[0] !== 1'b1) begin
            fails++;
            $display("FAIL stale_key: got key=%h kv=%b, expected 123456 1", key[0], kv[0]);
        end
        tests++;
        if (dbl_cnt[0] !== 0) begin
            fails++;
            $display("FAIL double_pulse: got %0d, expected 0", dbl_cnt[0]);
        end
        stale[0] = 0;
    endtask

    task automatic test_reset_mid;
        int p0;
        int p1;
        bit ok;
        men[0] = 1'b0;
        p0 = pcnt[0];
        pulse_en(0);
        for (int n = 0; n < 100 && pcnt[0] - p0 < 2; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({rdy[0], kv[0], c_en[0]} !== 3'b100 || {key[0], cur_low[0], c_lo[0], c_hi[0]} !== 96'h0) begin
            fails++;
            $display("FAIL async_reset: got rdy=%b kv=%b en=%b lo=%h hi=%h cur=%h, expected 1 0 0 0 0 0",
                     rdy[0], kv[0], c_en[0], c_lo[0], c_hi[0], cur_low[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        p1 = pcnt[0];
        repeat (3) @(negedge clk);
        tests++;
        if (pcnt[0] !== p1 || rdy[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_pulse: got pulses=%0d rdy=%b, expected 0 1", pcnt[0] - p1, rdy[0]);
        end
        p1 = pcnt[0];
        pulse_en(0);
        @(negedge clk);
        tests++;
        if (c_en[0] !== 1'b1 || c_lo[0] !== 24'h0) begin
            fails++;
            $display("FAIL restart_low: got en=%b lo=%h, expected 1 000000", c_en[0], c_lo[0]);
        end
        repeat (3) pulse_en(0);
        wait_rdy(0, 200, ok);
        tests++;
        if (!ok || pcnt[0] - p1 !== 4 || plo[0][p1+1] !== 24'h400000 || plo[0][p1+3] !== 24'hC00000) begin
            fails++;
            $display("FAIL busy_en_ignored: got pulses=%0d lo1=%h lo3=%h, expected 4 400000 c00000",
                     pcnt[0] - p1, plo[0][p1+1], plo[0][p1+3]);
        end
    endtask

    task automatic test_restart_done;
        int p0;
        bit ok;
        men[0] = 1'b1;
        mk[0] = 24'h8A1234;
        pulse_en(0);
        wait_rdy(0, 200, ok);
        tests++;
        if (!ok || kv[0] !== 1'b1) begin
            fails++;
            $display("FAIL restart_pre: got kv=%b ok=%b, expected 1 1", kv[0], ok);
        end
        men[0] = 1'b0;
        p0 = pcnt[0];
        pulse_en(0);
        tests++;
        if (kv[0] !== 1'b0 || rdy[0] !== 1'b0 || key[0] !== 24'h0) begin
            fails++;
            $display("FAIL restart_clear: got kv=%b rdy=%b key=%h, expected 0 0 000000", kv[0], rdy[0], key[0]);
        end
        @(negedge clk);
        tests++;
        if (c_en[0] !== 1'b1 || c_lo[0] !== 24'h0) begin
            fails++;
            $display("FAIL restart_reissue: got en=%b lo=%h, expected 1 000000", c_en[0], c_lo[0]);
        end
        wait_rdy(0, 200, ok);
        tests++;
        if (!ok || pcnt[0] - p0 !== 4 || kv[0] !== 1'b0) begin
            fails++;
            $display("FAIL restart_sweep: got pulses=%0d kv=%b, expected 4 0", pcnt[0] - p0, kv[0]);
        end
        tests++;
        if (dbl_cnt[0] !== 0 || dbl_cnt[1] !== 0) begin
            fails++;
            $display("FAIL double_pulse_total: got %0d/%0d, expected 0/0", dbl_cnt[0], dbl_cnt[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0;
            hold_until[i] = 0;
            stale[i] = 0;
            mk[i] = '0;
            men[i] = 1'b0;
            pcnt[i] = 0;
            dbl_cnt[i] = 0;
            rise_cyc[i] = 0;
            done_cyc[i] = 0;
        end
        test_reset;
        test_full_miss;
        test_hit;
        test_partial;
        test_handshake;
        test_reset_mid;
        test_restart_done;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
